q_argmax_pipe: RTL and testbench

- Parametrised, pipelined successor to the Q-value max block of the RL datapath.
- Takes N_ACT Q-values for one state each cycle and returns the maximum value and its action index (argmax).
- Supports a per-action valid mask, signed or unsigned compare, and a valid handshake.
- Feeds the Q-update target computation and greedy action selection.

---
 rtl/q_argmax_pipe.sv | 136 +++++++++++++
 tb/tb_q_argmax_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/q_argmax_pipe.sv
// Pipelined argmax over N_ACT Q-values: one compare-tree level per register stage.
// Optional macro Q_ARGMAX_BACKPRESSURE_EN adds out_ready and a stallable pipeline.
`timescale 1ns/1ps
module q_argmax_pipe #(
    parameter  int N_ACT  = 15,
    parameter  int DW     = 16,
    parameter  int SIGNED = 0,
    localparam int IDXW   = (N_ACT > 1) ? $clog2(N_ACT) : 1,
    localparam int LAT    = IDXW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_ACT*DW-1:0]   q_in,
    input  logic [N_ACT-1:0]      act_mask,
`ifdef Q_ARGMAX_BACKPRESSURE_EN
    input  logic                  out_ready,
`endif
    output logic                  out_valid,
    output logic [DW-1:0]         q_max,
    output logic [IDXW-1:0]       a_max,
    output logic                  none_valid
);

    // Node layout: {eligible, index, value}
    localparam int NW = DW + IDXW + 1;

    function automatic int node_cnt(input int lvl);
        return (N_ACT + (1 << lvl) - 1) >> lvl;
    endfunction

    function automatic logic b_gt_a(input logic [DW-1:0] b, input logic [DW-1:0] a);
        if (SIGNED != 0) return $signed(b) > $signed(a);
        return b > a;
    endfunction

    // An all-zero node is ineligible, so merging with it doubles as the odd-node pass-through.
    function automatic logic [NW-1:0] merge(input logic [NW-1:0] a, input logic [NW-1:0] b);
        if (a[NW-1] && b[NW-1]) return b_gt_a(b[DW-1:0], a[DW-1:0]) ? b : a;
        if (b[NW-1]) return b;
        if (a[NW-1]) return a;
        return '0;
    endfunction

    logic           out_rdy_int;
    logic [LAT:0]   stage_vld;
    logic [LAT:0]   rdy;
    logic           seen_q, seen_d;

`ifdef Q_ARGMAX_BACKPRESSURE_EN
    assign out_rdy_int = out_ready;
    assign in_ready    = !(out_valid && !out_ready);
`else
    assign out_rdy_int = 1'b1;
    assign in_ready    = 1'b1;
`endif

    // A stage may load when it is empty or the stage after it is moving.
    always_comb begin
        logic r;
        r   = out_rdy_int;
        rdy = '0;
        for (int s = LAT; s >= 0; s--) begin
            r      = !stage_vld[s] || r;
            rdy[s] = r;
        end
    end

    for (genvar gi = 0; gi <= LAT; gi++) begin : g_stage
        localparam int CNT = node_cnt(gi);
        logic [CNT*NW-1:0] node_q, node_d;
        logic              vld_q, vld_d;

        assign stage_vld[gi] = vld_q;

        if (gi == 0) begin : g_leaf
            always_comb begin
                vld_d  = vld_q;
                node_d = node_q;
                if (rdy[0]) begin
                    vld_d = in_valid && in_ready;
                    if (in_valid && in_ready) begin
                        for (int j = 0; j < CNT; j++) begin
                            node_d[j*NW +: NW] = {act_mask[j], IDXW'(j),
                                                  act_mask[j] ? q_in[j*DW +: DW] : {DW{1'b0}}};
                        end
                    end
                end
            end
        end else begin : g_node
            logic [2*CNT*NW-1:0] prev;
            assign prev = (2*CNT*NW)'(g_stage[gi-1].node_q);

            always_comb begin
                vld_d  = vld_q;
                node_d = node_q;
                if (rdy[gi]) begin
                    vld_d = g_stage[gi-1].vld_q;
                    if (g_stage[gi-1].vld_q) begin
                        for (int j = 0; j < CNT; j++) begin
                            node_d[j*NW +: NW] = merge(prev[(2*j)*NW +: NW], prev[(2*j+1)*NW +: NW]);
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                node_q <= '0;
            end else begin
                vld_q  <= vld_d;
                node_q <= node_d;
            end
        end
    end

    // Keeps none_valid low until the first result has been produced.
    always_comb begin
        seen_d = seen_q;
        if (rdy[LAT] && stage_vld[LAT-1]) seen_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seen_q <= 1'b0;
        else        seen_q <= seen_d;
    end

    assign out_valid  = g_stage[LAT].vld_q;
    assign q_max      = g_stage[LAT].node_q[DW-1:0];
    assign a_max      = g_stage[LAT].node_q[DW +: IDXW];
    assign none_valid = seen_q && !g_stage[LAT].node_q[NW-1];

endmodule

// File: tb/tb_q_argmax_pipe.sv
// Directed, table-driven bench for q_argmax_pipe (unsigned and signed instances side by side).
`timescale 1ns/1ps
module tb_q_argmax_pipe;
    localparam int N  = 15;
    localparam int W  = 16;
    localparam int L  = 4;
    localparam int IW = 4;
    localparam int NV = 11;

    logic            clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, in_valid;
    logic [N*W-1:0]  q_in;
    logic [N-1:0]    act_mask;
    logic            in_ready, out_valid, none_valid;
    logic [W-1:0]    q_max;
    logic [IW-1:0]   a_max;
    logic            s_in_ready, s_out_valid, s_none;
    logic [W-1:0]    s_q;
    logic [IW-1:0]   s_a;
`ifdef Q_ARGMAX_BACKPRESSURE_EN
    logic            out_ready;
`endif

    q_argmax_pipe #(.N_ACT(N), .DW(W), .SIGNED(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .q_in(q_in), .act_mask(act_mask),
`ifdef Q_ARGMAX_BACKPRESSURE_EN
        .out_ready(out_ready),
`endif
        .out_valid(out_valid), .q_max(q_max), .a_max(a_max), .none_valid(none_valid)
    );

    q_argmax_pipe #(.N_ACT(N), .DW(W), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .q_in(q_in), .act_mask(act_mask),
`ifdef Q_ARGMAX_BACKPRESSURE_EN
        .out_ready(out_ready),
`endif
        .out_valid(s_out_valid), .q_max(s_q), .a_max(s_a), .none_valid(s_none)
    );

    typedef struct {
        logic [N*W-1:0] q;
        logic [N-1:0]   m;
        logic [W-1:0]   eq;
        logic [IW-1:0]  ea;
        logic           en;
        logic [W-1:0]   sq;
        logic [IW-1:0]  sa;
        logic           sn;
    } vec_t;

    vec_t tbl [0:NV-1];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k);
        in_valid = 1'b1;
        q_in     = tbl[k].q;
        act_mask = tbl[k].m;
    endtask

    task automatic chk_result(input string tag, input int k);
        chk({tag, " q_max"},      32'(q_max),      32'(tbl[k].eq));
        chk({tag, " a_max"},      32'(a_max),      32'(tbl[k].ea));
        chk({tag, " none_valid"}, 32'(none_valid), 32'(tbl[k].en));
    endtask

    function automatic logic [N*W-1:0] mkq(input logic [W-1:0] v0, input logic [W-1:0] v1,
                                           input logic [W-1:0] v2, input logic [W-1:0] v3,
                                           input logic [W-1:0] v14);
        logic [N*W-1:0] r;
        r = '0;
        r[0*W +: W]  = v0;
        r[1*W +: W]  = v1;
        r[2*W +: W]  = v2;
        r[3*W +: W]  = v3;
        r[14*W +: W] = v14;
        return r;
    endfunction

    initial begin
        //             q                                        mask      eq        ea  en    sq        sa  sn
        tbl[0]  = '{mkq(16'd1, 16'd2, 16'd3, 16'd4, 16'd0),    15'h7FFF, 16'd4,    4'd3,  1'b0, 16'd4,    4'd3,  1'b0};
        tbl[1]  = '{mkq(16'd2, 16'd3, 16'd6, 16'd1, 16'd0),    15'h7FFF, 16'd6,    4'd2,  1'b0, 16'd6,    4'd2,  1'b0};
        tbl[2]  = '{mkq(16'd5, 16'd4, 16'd1, 16'd2, 16'd0),    15'h7FFF, 16'd5,    4'd0,  1'b0, 16'd5,    4'd0,  1'b0};
        tbl[3]  = '{mkq(16'd7, 16'd7, 16'd0, 16'd0, 16'd0),    15'h7FFF, 16'd7,    4'd0,  1'b0, 16'd7,    4'd0,  1'b0};
        tbl[4]  = '{mkq(16'd7, 16'd7, 16'd0, 16'd0, 16'd0),    15'h7FFE, 16'd7,    4'd1,  1'b0, 16'd7,    4'd1,  1'b0};
        tbl[5]  = '{mkq(16'd7, 16'd7, 16'd0, 16'd0, 16'd0),    15'h0000, 16'd0,    4'd0,  1'b1, 16'd0,    4'd0,  1'b1};
        tbl[6]  = '{mkq(16'hFFFF, 16'h0, 16'h8000, 16'h0, 16'h0), 15'h7FFF, 16'hFFFF, 4'd0, 1'b0, 16'h0000, 4'd1, 1'b0};
        tbl[7]  = '{mkq(16'd0, 16'd0, 16'd0, 16'd0, 16'd9),    15'h7FFF, 16'd9,    4'd14, 1'b0, 16'd9,    4'd14, 1'b0};
        tbl[8]  = '{mkq(16'd100, 16'd50, 16'd0, 16'd0, 16'd3), 15'h4000, 16'd3,    4'd14, 1'b0, 16'd3,    4'd14, 1'b0};
        tbl[9]  = '{mkq(16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0), 15'h7FFE, 16'd0,    4'd1,  1'b0, 16'd0,    4'd1,  1'b0};
        tbl[10] = '{mkq(16'h7FFF, 16'h8000, 16'd0, 16'd0, 16'd0), 15'h0003, 16'h8000, 4'd1, 1'b0, 16'h7FFF, 4'd0, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        q_in     = '0;
        act_mask = '0;
`ifdef Q_ARGMAX_BACKPRESSURE_EN
        out_ready = 1'b1;
`endif
        tick;
        tick;
        chk("reset out_valid",  32'(out_valid),  32'd0);
        chk("reset q_max",      32'(q_max),      32'd0);
        chk("reset a_max",      32'(a_max),      32'd0);
        chk("reset none_valid", 32'(none_valid), 32'd0);
        chk("reset in_ready",   32'(in_ready),   32'd1);
        rst_n = 1'b1;
        tick;

        // Back-to-back vectors: vector c is accepted at this cycle's edge, result L edges later.
        for (int c = 0; c < NV + L; c++) begin
            if (c < NV) drive(c);
            else        in_valid = 1'b0;
            tick;
            begin
                int  k;
                logic ev;
                k  = c - L;
                ev = (k >= 0) && (k < NV);
                chk("tbl out_valid", 32'(out_valid), 32'(ev));
                if (ev) begin
                    chk_result("tbl", k);
                    chk("tbl signed q_max",      32'(s_q),    32'(tbl[k].sq));
                    chk("tbl signed a_max",      32'(s_a),    32'(tbl[k].sa));
                    chk("tbl signed none_valid", 32'(s_none), 32'(tbl[k].sn));
                    $display("[TB] vec %0d: q_max=0x%h a_max=%0d none=%0d | signed q_max=0x%h a_max=%0d",
                             k, q_max, a_max, none_valid, s_q, s_a);
                end
            end
        end

        // Gapped input 1,0,1: a bubble reaches the output and values hold across it.
        for (int c = 0; c < L + 4; c++) begin
            if (c == 0)      drive(0);
            else if (c == 2) drive(2);
            else begin
                in_valid = 1'b0;
                q_in     = '1;
                act_mask = '1;
            end
            tick;
            chk("gap out_valid", 32'(out_valid), 32'((c == L) || (c == L + 2)));
            if (c >= L) begin
                chk_result("gap", (c < L + 2) ? 0 : 2);
                $display("[TB] gap cycle %0d: out_valid=%0d q_max=0x%h a_max=%0d", c, out_valid, q_max, a_max);
            end
        end

        // Reset while vectors are in flight.
        drive(0);
        tick;
        drive(1);
        tick;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst out_valid",  32'(out_valid),  32'd0);
        chk("midrst q_max",      32'(q_max),      32'd0);
        chk("midrst a_max",      32'(a_max),      32'd0);
        chk("midrst none_valid", 32'(none_valid), 32'd0);
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < L + 2; c++) begin
            tick;
            chk("postrst idle out_valid", 32'(out_valid), 32'd0);
            chk("postrst idle q_max",     32'(q_max),     32'd0);
        end
        for (int c = 0; c <= L; c++) begin
            if (c == 0) drive(1);
            else        in_valid = 1'b0;
            tick;
            chk("postrst out_valid", 32'(out_valid), 32'(c == L));
        end
        chk_result("postrst", 1);
        $display("[TB] post-reset result: q_max=0x%h a_max=%0d", q_max, a_max);
        in_valid = 1'b0;
        tick;

`ifdef Q_ARGMAX_BACKPRESSURE_EN
        // Stall with a full pipe for 5 cycles, then drain; order and count must be preserved.
        begin
            int sb[$];
            int next_in   = 0;
            int delivered = 0;
            for (int c = 0; c < 40 && delivered < 8; c++) begin
                out_ready = !(c >= 5 && c <= 9);
                if (next_in < 8) drive(next_in);
                else             in_valid = 1'b0;
                #1;
                if (c >= 5 && c <= 9) chk("bp in_ready stalled", 32'(in_ready), 32'd0);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("bp spurious out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        chk_result("bp", sb[0]);
                        if (out_ready) begin
                            $display("[TB] bp delivered vec %0d: q_max=0x%h a_max=%0d", sb[0], q_max, a_max);
                            void'(sb.pop_front());
                            delivered++;
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back(next_in);
                    next_in++;
                end
                tick;
            end
            chk("bp delivered count", 32'(delivered), 32'd8);
            chk("bp leftover count",  32'(sb.size()), 32'd0);
            out_ready = 1'b1;
            in_valid  = 1'b0;
            tick;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
